fifo_module: RTL and testbench

- Parameterised first-word-fall-through (FWFT) byte FIFO. Two instances sit between the UART and the ALU interface stage.
- RX side: the UART receiver writes bytes in; the interface stage reads opcode, operand A and operand B out.
- TX side: the interface stage writes the result in; the UART transmitter drains it.
- Adds occupancy count and sticky overflow/underflow error flags for debug.

---
 rtl/fifo_module.sv | 93 +++++++++
 tb/tb_fifo_module.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/fifo_module.sv
// First-word-fall-through byte FIFO with occupancy count and sticky
// overflow/underflow flags; sits between the UART and the ALU interface stage.
module fifo_module #(
    parameter int NB_FIFOMODULE_DATA = 8,
    parameter int NB_FIFOMODULE_ADDR = 4
) (
    input  logic                          i_clk,
    input  logic                          i_reset,
    input  logic                          i_fifomodule_WRITE,
    input  logic [NB_FIFOMODULE_DATA-1:0] i_fifomodule_WRITEDATA,
    input  logic                          i_fifomodule_READ,
    output logic [NB_FIFOMODULE_DATA-1:0] o_fifomodule_READDATA,
    output logic                          o_fifomodule_EMPTY,
    output logic                          o_fifomodule_FULL,
    output logic [NB_FIFOMODULE_ADDR:0]   o_fifomodule_COUNT,
    input  logic                          i_fifomodule_CLRERR,
    output logic                          o_fifomodule_OVERFLOW,
    output logic                          o_fifomodule_UNDERFLOW
);

    localparam int DEPTH = 2 ** NB_FIFOMODULE_ADDR;
    localparam int NB_PTR = NB_FIFOMODULE_ADDR + 1;

    logic [NB_FIFOMODULE_DATA-1:0] mem [DEPTH];

    logic [NB_PTR-1:0] wr_ptr;
    logic [NB_PTR-1:0] rd_ptr;
    logic [NB_PTR-1:0] wr_ptr_nxt;
    logic [NB_PTR-1:0] rd_ptr_nxt;
    logic [NB_PTR-1:0] count;
    logic              empty;
    logic              full;
    logic              overflow;
    logic              underflow;

    logic rd_accept;
    logic wr_accept;
    logic ovf_event;
    logic unf_event;

    // When full, a coincident read frees the head slot on the same edge,
    // so the write is still taken.
    always_comb begin
        rd_accept  = i_fifomodule_READ & ~empty;
        wr_accept  = i_fifomodule_WRITE & (~full | rd_accept);
        ovf_event  = i_fifomodule_WRITE & ~wr_accept;
        unf_event  = i_fifomodule_READ & empty;
        wr_ptr_nxt = wr_accept ? wr_ptr + NB_PTR'(1) : wr_ptr;
        rd_ptr_nxt = rd_accept ? rd_ptr + NB_PTR'(1) : rd_ptr;
    end

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            empty     <= 1'b1;
            full      <= 1'b0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            wr_ptr <= wr_ptr_nxt;
            rd_ptr <= rd_ptr_nxt;
            count  <= wr_ptr_nxt - rd_ptr_nxt;
            empty  <= (wr_ptr_nxt == rd_ptr_nxt);
            full   <= (wr_ptr_nxt[NB_FIFOMODULE_ADDR] != rd_ptr_nxt[NB_FIFOMODULE_ADDR]) &&
                      (wr_ptr_nxt[NB_FIFOMODULE_ADDR-1:0] == rd_ptr_nxt[NB_FIFOMODULE_ADDR-1:0]);
            // A new error event wins over a coincident clear.
            if (ovf_event)
                overflow <= 1'b1;
            else if (i_fifomodule_CLRERR)
                overflow <= 1'b0;
            if (unf_event)
                underflow <= 1'b1;
            else if (i_fifomodule_CLRERR)
                underflow <= 1'b0;
        end
    end

    // Storage is deliberately left out of reset.
    always_ff @(posedge i_clk) begin
        if (wr_accept)
            mem[wr_ptr[NB_FIFOMODULE_ADDR-1:0]] <= i_fifomodule_WRITEDATA;
    end

    assign o_fifomodule_READDATA  = empty ? '0 : mem[rd_ptr[NB_FIFOMODULE_ADDR-1:0]];
    assign o_fifomodule_EMPTY     = empty;
    assign o_fifomodule_FULL      = full;
    assign o_fifomodule_COUNT     = count;
    assign o_fifomodule_OVERFLOW  = overflow;
    assign o_fifomodule_UNDERFLOW = underflow;

endmodule

// File: tb/tb_fifo_module.sv
// Bench for fifo_module: directed scenarios plus random traffic, all checked
// against a queue-based model of the FIFO's rules.
module tb_fifo_module;

    localparam int NB_DATA = 8;
    localparam int NB_ADDR = 4;
    localparam int DEPTH   = 2 ** NB_ADDR;

    logic               i_clk = 1'b0;
    logic               i_reset = 1'b0;
    logic               wr = 1'b0;
    logic [NB_DATA-1:0] wdata = '0;
    logic               rd = 1'b0;
    logic [NB_DATA-1:0] rdata;
    logic               empty;
    logic               full;
    logic [NB_ADDR:0]   count;
    logic               clrerr = 1'b0;
    logic               ovf;
    logic               unf;

    int n_checks = 0;
    int n_errors = 0;

    logic [NB_DATA-1:0] q[$];
    logic               m_ovf = 1'b0;
    logic               m_unf = 1'b0;

    fifo_module #(
        .NB_FIFOMODULE_DATA(NB_DATA),
        .NB_FIFOMODULE_ADDR(NB_ADDR)
    ) dut (
        .i_clk                 (i_clk),
        .i_reset               (i_reset),
        .i_fifomodule_WRITE    (wr),
        .i_fifomodule_WRITEDATA(wdata),
        .i_fifomodule_READ     (rd),
        .o_fifomodule_READDATA (rdata),
        .o_fifomodule_EMPTY    (empty),
        .o_fifomodule_FULL     (full),
        .o_fifomodule_COUNT    (count),
        .i_fifomodule_CLRERR   (clrerr),
        .o_fifomodule_OVERFLOW (ovf),
        .o_fifomodule_UNDERFLOW(unf)
    );

    always #5 i_clk = ~i_clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s observed=0x%0h expected=0x%0h t=%0t", tag, obs, exp, $time);
        end
    endtask

    task automatic check_model(input string tag);
        logic [NB_DATA-1:0] exp_data;
        exp_data = (q.size() != 0) ? q[0] : '0;
        check({tag, ".count"}, 32'(count), 32'(q.size()));
        check({tag, ".empty"}, 32'(empty), 32'(q.size() == 0));
        check({tag, ".full"},  32'(full),  32'(q.size() == DEPTH));
        check({tag, ".data"},  32'(rdata), 32'(exp_data));
        check({tag, ".ovf"},   32'(ovf),   32'(m_ovf));
        check({tag, ".unf"},   32'(unf),   32'(m_unf));
    endtask

    // Applies one cycle of stimulus, advances the model at the edge and
    // compares all outputs half a cycle later.
    task automatic step(input logic w, input logic [NB_DATA-1:0] d, input logic r,
                        input logic c, input string tag);
        bit was_empty, was_full, rd_ok, wr_ok;
        wr = w; wdata = d; rd = r; clrerr = c;
        @(posedge i_clk);
        was_empty = (q.size() == 0);
        was_full  = (q.size() == DEPTH);
        rd_ok = r && !was_empty;
        wr_ok = w && (!was_full || rd_ok);
        if (rd_ok) void'(q.pop_front());
        if (wr_ok) q.push_back(d);
        m_ovf = (w && !wr_ok) ? 1'b1 : (c ? 1'b0 : m_ovf);
        m_unf = (r && was_empty) ? 1'b1 : (c ? 1'b0 : m_unf);
        @(negedge i_clk);
        wr = 1'b0; rd = 1'b0; clrerr = 1'b0;
        check_model(tag);
    endtask

    initial begin
        repeat (2) @(negedge i_clk);
        i_reset = 1'b1;
        @(negedge i_clk);
        check("rst.empty", 32'(empty), 32'd1);
        check("rst.full",  32'(full),  32'd0);
        check("rst.count", 32'(count), 32'd0);
        check("rst.data",  32'(rdata), 32'h00);
        check("rst.ovf",   32'(ovf),   32'd0);
        check("rst.unf",   32'(unf),   32'd0);

        // Opcode / operand A / operand B
        step(1, 8'h2A, 0, 0, "rx_w0");
        step(1, 8'h05, 0, 0, "rx_w1");
        step(1, 8'h03, 0, 0, "rx_w2");
        check("rx.count3", 32'(count), 32'd3);
        check("rx.op", 32'(rdata), 32'h2A);
        step(0, 0, 1, 0, "rx_r0");
        check("rx.a", 32'(rdata), 32'h05);
        check("rx.count2", 32'(count), 32'd2);
        step(0, 0, 1, 0, "rx_r1");
        check("rx.b", 32'(rdata), 32'h03);
        check("rx.count1", 32'(count), 32'd1);
        step(0, 0, 1, 0, "rx_r2");
        check("rx.empty", 32'(empty), 32'd1);
        check("rx.unf", 32'(unf), 32'd0);

        // Fill, overflow, full-and-both, drain across the wrap
        for (int i = 0; i < DEPTH; i++) step(1, NB_DATA'(i), 0, 0, "fill");
        check("fill.full", 32'(full), 32'd1);
        check("fill.count", 32'(count), 32'd16);
        step(1, 8'hFF, 0, 0, "ovf_wr");
        check("ovf.flag", 32'(ovf), 32'd1);
        check("ovf.head", 32'(rdata), 32'h00);
        step(1, 8'hAA, 1, 0, "full_both");
        check("fb.full", 32'(full), 32'd1);
        check("fb.count", 32'(count), 32'd16);
        for (int i = 1; i < DEPTH; i++) begin
            check("drain.data", 32'(rdata), 32'(i));
            step(0, 0, 1, 0, "drain");
        end
        check("drain.last", 32'(rdata), 32'hAA);
        step(0, 0, 1, 0, "drain_aa");
        check("drain.empty", 32'(empty), 32'd1);

        // Empty-and-both, clear, clear coinciding with an error
        step(1, 8'h55, 1, 0, "empty_both");
        check("eb.count", 32'(count), 32'd1);
        check("eb.data", 32'(rdata), 32'h55);
        check("eb.unf", 32'(unf), 32'd1);
        step(0, 0, 0, 1, "clr");
        check("clr.unf", 32'(unf), 32'd0);
        check("clr.ovf", 32'(ovf), 32'd0);
        step(0, 0, 1, 0, "pop55");
        step(0, 0, 1, 1, "clr_vs_unf");
        check("clrset.unf", 32'(unf), 32'd1);

        // Asynchronous reset with seven entries queued
        for (int i = 0; i < 7; i++) step(1, NB_DATA'(8'h40 + i), 0, 0, "pre_rst");
        check("pre_rst.count", 32'(count), 32'd7);
        @(posedge i_clk);
        #2 i_reset = 1'b0;
        #1;
        check("arst.empty", 32'(empty), 32'd1);
        check("arst.count", 32'(count), 32'd0);
        check("arst.unf", 32'(unf), 32'd0);
        q.delete(); m_ovf = 1'b0; m_unf = 1'b0;
        @(negedge i_clk);
        i_reset = 1'b1;
        step(1, 8'h11, 0, 0, "post_rst_w");
        check("post_rst.data", 32'(rdata), 32'h11);

        // Random traffic
        for (int i = 0; i < 3000; i++) begin
            int unsigned bias;
            bias = (i / 300) % 3;
            step(($urandom_range(99) < (bias == 0 ? 70 : (bias == 1 ? 30 : 50))),
                 NB_DATA'($urandom),
                 ($urandom_range(99) < (bias == 0 ? 30 : (bias == 1 ? 70 : 50))),
                 ($urandom_range(99) < 5), "rand");
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
